// File: rtl/mux8_sched_pkg.sv
// rtl/mux8_sched_pkg.sv - shared types and constants for the 8-way round-robin mux scheduler
package mux8_sched_pkg;

  localparam int N_SRC = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    GRANT  = 2'd2
  } sched_state_t;

  function automatic logic [N_SRC-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [N_SRC-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - rotate-priority picker: first set request at or after ptr, ascending with wrap
module rr_pick8
  import mux8_sched_pkg::*;
(
  input  logic [7:0]       req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [15:0]      dbl;
  logic [7:0]       rot;
  logic [SEL_W-1:0] off;

  // Doubling the vector turns the wrap-around search into a plain slice.
  assign dbl = {req, req};
  assign rot = dbl[ptr +: 8];

  always_comb begin
    off = '0;
    for (int k = 7; k >= 0; k--) begin
      if (rot[k]) off = SEL_W'(k);
    end
  end

  assign idx = ptr + off;
  assign any = |req;

endmodule

// File: rtl/mux8_rr_sched.sv
// rtl/mux8_rr_sched.sv - round-robin select scheduler for a shared 8x1 transmission-gate mux
// A dead SWITCH cycle separates every select change from the following valid window.
module mux8_rr_sched #(
  parameter int N_SRC  = 8,
  parameter int HOLD_W = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_SRC-1:0]                 req,
  input  logic [HOLD_W-1:0]                hold_len,
  output logic [mux8_sched_pkg::SEL_W-1:0] s,
  output logic [mux8_sched_pkg::SEL_W-1:0] sbar,
  output logic [N_SRC-1:0]                 gnt,
  output logic                             valid
);
  import mux8_sched_pkg::*;

  sched_state_t     state, state_n;
  logic [SEL_W-1:0] last, last_n;
  logic [SEL_W-1:0] s_n;
  logic [N_SRC-1:0] gnt_n;
  logic             valid_n;
  logic [HOLD_W-1:0] cnt, cnt_n;

  logic [SEL_W-1:0]  pick_ptr;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_any;
  logic [HOLD_W-1:0] dwell;
  logic              grant_end;

  // Search begins just past the last grant, so the current owner is always the lowest priority.
  assign pick_ptr  = last + SEL_W'(1);
  assign dwell     = (hold_len == '0) ? HOLD_W'(1) : hold_len;
  assign grant_end = (cnt == HOLD_W'(1)) || !req[s];

  rr_pick8 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_n = state;
    s_n     = s;
    gnt_n   = gnt;
    valid_n = valid;
    last_n  = last;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        gnt_n   = '0;
        valid_n = 1'b0;
        if (pick_any) begin
          state_n = SWITCH;
          s_n     = pick_idx;
          gnt_n   = onehot8(pick_idx);
          last_n  = pick_idx;
        end
      end
      SWITCH: begin
        state_n = GRANT;
        valid_n = 1'b1;
        cnt_n   = dwell;
      end
      GRANT: begin
        if (!grant_end) begin
          cnt_n = cnt - HOLD_W'(1);
        end else if (!pick_any) begin
          state_n = IDLE;
          gnt_n   = '0;
          valid_n = 1'b0;
        end else if (pick_idx == s) begin
          // Sole requester keeps the path: no select change, so no dead cycle.
          cnt_n = dwell;
        end else begin
          state_n = SWITCH;
          s_n     = pick_idx;
          gnt_n   = onehot8(pick_idx);
          valid_n = 1'b0;
          last_n  = pick_idx;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s     <= '0;
      sbar  <= '1;
      gnt   <= '0;
      valid <= 1'b0;
      last  <= SEL_W'(7);
      cnt   <= '0;
    end else begin
      state <= state_n;
      s     <= s_n;
      sbar  <= ~s_n;
      gnt   <= gnt_n;
      valid <= valid_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_mux8_rr_sched.sv
// tb/tb_mux8_rr_sched.sv - directed table and sequence checks for mux8_rr_sched
module tb_mux8_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [3:0] hold_len;
  logic [2:0] s, sbar;
  logic [7:0] gnt;
  logic       valid;

  int checks = 0;
  int errors = 0;
  logic [2:0] prev_s = 3'bxxx;

  typedef struct packed {
    logic       rst;
    logic [7:0] req;
    logic [3:0] hold;
    logic [2:0] es;
    logic       ev;
    logic [7:0] eg;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  mux8_rr_sched #(.N_SRC(8), .HOLD_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .hold_len (hold_len),
    .s        (s),
    .sbar     (sbar),
    .gnt      (gnt),
    .valid    (valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] es, input logic ev, input logic [7:0] eg);
    logic [2:0] esb;
    esb = ~es;
    chk({tag, ".s"}, 32'(s), 32'(es));
    chk({tag, ".sbar"}, 32'(sbar), 32'(esb));
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
  endtask

  // Advance one edge and sample 1 time unit later; also guard valid against a select change.
  task automatic tick();
    @(posedge clk);
    #1;
    if (s !== prev_s) chk("valid_low_on_s_change", 32'(valid), 32'(0));
    prev_s = s;
  endtask

  task automatic drive(input logic r, input logic [7:0] q, input logic [3:0] h);
    rst      = r;
    req      = q;
    hold_len = h;
  endtask

  initial begin
    drive(1'b1, 8'h00, 4'd0);

    //           rst   req    hold  s     valid gnt
    tbl[0]  = '{1'b1, 8'h00, 4'd0, 3'd0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h00, 4'd0, 3'd0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 8'h01, 4'd1, 3'd0, 1'b0, 8'h01};
    tbl[3]  = '{1'b0, 8'h01, 4'd1, 3'd0, 1'b1, 8'h01};
    tbl[4]  = '{1'b0, 8'h00, 4'd1, 3'd0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 8'h00, 4'd1, 3'd0, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 8'h11, 4'd0, 3'd4, 1'b0, 8'h10};
    tbl[7]  = '{1'b0, 8'h11, 4'd0, 3'd4, 1'b1, 8'h10};
    tbl[8]  = '{1'b0, 8'h11, 4'd0, 3'd0, 1'b0, 8'h01};
    tbl[9]  = '{1'b0, 8'h11, 4'd0, 3'd0, 1'b1, 8'h01};
    tbl[10] = '{1'b0, 8'h11, 4'd0, 3'd4, 1'b0, 8'h10};
    tbl[11] = '{1'b0, 8'h11, 4'd0, 3'd4, 1'b1, 8'h10};
    tbl[12] = '{1'b0, 8'h00, 4'd0, 3'd4, 1'b0, 8'h00};
    tbl[13] = '{1'b0, 8'h00, 4'd0, 3'd4, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 8'h08, 4'd8, 3'd3, 1'b0, 8'h08};
    tbl[15] = '{1'b0, 8'h08, 4'd8, 3'd3, 1'b1, 8'h08};
    tbl[16] = '{1'b0, 8'h28, 4'd0, 3'd3, 1'b1, 8'h08};
    tbl[17] = '{1'b0, 8'h20, 4'd0, 3'd5, 1'b0, 8'h20};
    tbl[18] = '{1'b0, 8'h20, 4'd1, 3'd5, 1'b1, 8'h20};
    tbl[19] = '{1'b0, 8'h28, 4'd1, 3'd3, 1'b0, 8'h08};
    tbl[20] = '{1'b0, 8'h28, 4'd2, 3'd3, 1'b1, 8'h08};
    tbl[21] = '{1'b0, 8'h28, 4'd2, 3'd3, 1'b1, 8'h08};
    tbl[22] = '{1'b0, 8'h20, 4'd2, 3'd5, 1'b0, 8'h20};
    tbl[23] = '{1'b0, 8'h00, 4'd1, 3'd5, 1'b1, 8'h20};
    tbl[24] = '{1'b0, 8'h00, 4'd1, 3'd5, 1'b0, 8'h00};

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].hold);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].es, tbl[i].ev, tbl[i].eg);
    end

    // Full round robin, two valid cycles per grant, wraps back to 0.
    drive(1'b1, 8'h00, 4'd0);
    tick();
    chk_out("rr_reset", 3'd0, 1'b0, 8'h00);
    drive(1'b0, 8'hFF, 4'd2);
    for (int g = 0; g < 9; g++) begin
      logic [2:0] k;
      k = 3'(g % 8);
      tick();
      chk_out($sformatf("rr%0d_switch", g), k, 1'b0, 8'h01 << k);
      tick();
      chk_out($sformatf("rr%0d_grant_a", g), k, 1'b1, 8'h01 << k);
      tick();
      chk_out($sformatf("rr%0d_grant_b", g), k, 1'b1, 8'h01 << k);
    end

    // Sole requester holds the path with no dead cycle across dwell reloads.
    drive(1'b1, 8'h00, 4'd0);
    tick();
    drive(1'b0, 8'h40, 4'd3);
    tick();
    chk_out("sole_switch", 3'd6, 1'b0, 8'h40);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_out($sformatf("sole%0d", c), 3'd6, 1'b1, 8'h40);
    end

    // Reset in the middle of a grant, then the search restarts at index 0.
    drive(1'b1, 8'h00, 4'd0);
    tick();
    drive(1'b0, 8'h20, 4'd4);
    tick();
    chk_out("mid_switch", 3'd5, 1'b0, 8'h20);
    tick();
    chk_out("mid_grant_a", 3'd5, 1'b1, 8'h20);
    tick();
    chk_out("mid_grant_b", 3'd5, 1'b1, 8'h20);
    drive(1'b1, 8'hFF, 4'd4);
    tick();
    chk_out("mid_reset", 3'd0, 1'b0, 8'h00);
    drive(1'b0, 8'hFF, 4'd4);
    tick();
    chk_out("post_reset_switch", 3'd0, 1'b0, 8'h01);
    tick();
    chk_out("post_reset_grant", 3'd0, 1'b1, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux8_rr_sched.md
MUX8_RR_SCHED -- requirements
Module: mux8_rr_sched

Interface
REQ-001 Parameter N_SRC, default 8, is the number of requesters (equal to the mux width); only 8 is supported.
REQ-002 Parameter HOLD_W, default 4, is the width of the hold-length input and the dwell counter.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the reset: synchronous and active-high.
REQ-005 Port req  input  8  carries the per-source requests for the shared 8x1 transmission-gate mux path.
REQ-006 Port hold_len  input  HOLD_W  is the dwell time per grant in cycles; the value 0 is treated as 1.
REQ-007 Port s  output  3  is the mux select, registered.
REQ-008 Port sbar  output  3  is the complementary select, registered; it SHALL always equal ~s.
REQ-009 Port gnt  output  8  is the one-hot grant, or zero.
REQ-010 Port valid  output  1  indicates the mux path is settled and the output y belongs to the granted source.

Function
REQ-011 The FSM SHALL have three states: IDLE, SWITCH (one dead cycle while the select settles) and GRANT.
REQ-012 The round-robin pick SHALL search req starting at index (last+1) mod 8, ascending with wrap; last is the most recently granted index.
REQ-013 In IDLE with req != 0, the next state SHALL be SWITCH, with s/sbar loaded with the picked index, gnt set one-hot to it, valid=0, and last updated.
REQ-014 In IDLE with req == 0, s/sbar SHALL hold their previous value, with gnt=0 and valid=0.
REQ-015 SWITCH SHALL last exactly one cycle, then go to GRANT with valid=1 and the dwell counter loaded with max(hold_len,1); hold_len is sampled in this cycle only.
REQ-016 In GRANT, the counter SHALL decrement each cycle; the grant ends when the counter equals 1, or immediately when req[s] deasserts (early release).
REQ-017 At grant end, if another index is requesting, the next pick SHALL load s/sbar/gnt, set valid=0 and go to SWITCH.
REQ-018 At grant end, if only the current index is requesting, the FSM SHALL stay in GRANT with the counter reloaded, valid staying 1 and no dead cycle.
REQ-019 At grant end, if no index is requesting, the FSM SHALL go to IDLE with gnt=0 and valid=0.
REQ-020 Latency: a request in IDLE at cycle t SHALL produce s updated at t+1 and valid=1 at t+2.
REQ-021 valid SHALL never be 1 in the same cycle that s changes.
REQ-022 No source SHALL be starved: with continuous requests, each requester is granted within 7 grant periods.
REQ-023 When arbitration and early release coincide, the release SHALL take effect and the pick SHALL exclude the released index unless that index re-requests.

Reset
REQ-024 With rst=1 at a clock edge, the block SHALL set state=IDLE, s=3'b000, sbar=3'b111, gnt=0, valid=0, last=7 and counter=0.
REQ-025 Reset SHALL override any in-progress SWITCH or GRANT, and the first post-reset pick SHALL start its search at index 0.

Structure
REQ-026 The shared package mux8_sched_pkg SHALL hold the state enum (IDLE/SWITCH/GRANT), the N_SRC constant and the select-width constant (3).
REQ-027 The combinational rotate-priority picker SHALL be the sub-module rr_pick8 (inputs req[7:0] and ptr[2:0]; outputs idx[2:0] and any).
REQ-028 All outputs SHALL be flop-driven; the datapath mux is instantiated by the integrator, not inside this block.

Verification
REQ-029 Reset scenario: rst held 2 cycles -> s=0, sbar=7, gnt=0, valid=0; then req=8'h01 -> s=0 at t+1, valid=1 at t+2.
REQ-030 Round-robin scenario: req=8'hFF, hold_len=2 -> grant order 0,1,2,...,7,0 with one valid=0 cycle between grants; sbar==~s on every cycle.
REQ-031 Early-release scenario: grant on idx 3 with hold_len=8, req[3] dropped after 2 GRANT cycles, req[5]=1 -> SWITCH the next cycle, s=5.
REQ-032 Sole-requester scenario: only req[6] held, hold_len=3 -> valid stays 1 continuously and s stays 6, with no dead cycles.
REQ-033 hold_len=0 scenario: req=8'h11 -> each grant lasts exactly 1 GRANT cycle, alternating s=0 and s=4.
REQ-034 Mid-operation reset scenario: rst asserted during GRANT on idx 5 -> the next cycle is IDLE with outputs at reset values, and the next pick with req=8'hFF is idx 0.
